// File: rtl/store_data_aligner_pkg.sv
// Shared constants and types for the store data aligner.
// Covers the STORE opcode, the funct3 width codes and the FSM state encoding.
package store_pkg;

  localparam logic [6:0] OPCODE_STORE = 7'b0100011;
  localparam logic [2:0] F3_SB        = 3'b000;
  localparam logic [2:0] F3_SH        = 3'b001;
  localparam logic [2:0] F3_SW        = 3'b010;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT0 = 2'd1,
    BEAT1 = 2'd2,
    RESP  = 2'd3
  } state_e;

endpackage

// File: rtl/store_data_aligner_if.sv
// Request and memory-write bundle for the store data aligner.
// The slave modport is the aligner's view; master is the surrounding pipeline/memory.
interface store_data_aligner_if #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic [WIDTH-1:0]      inst;
  logic [ADDR_WIDTH-1:0] addr;
  logic [WIDTH-1:0]      wdata_in;
  logic                  mem_valid;
  logic                  mem_ready;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0]      mem_wdata;
  logic [3:0]            mem_be;
  logic                  done;
  logic                  illegal;

  modport slave (
    input  req_valid, inst, addr, wdata_in, mem_ready,
    output req_ready, mem_valid, mem_addr, mem_wdata, mem_be, done, illegal
  );

  modport master (
    output req_valid, inst, addr, wdata_in, mem_ready,
    input  req_ready, mem_valid, mem_addr, mem_wdata, mem_be, done, illegal
  );
endinterface

// File: rtl/store_data_aligner_lane_gen.sv
// Combinational lane generator for stores.
// Turns funct3/offset/data into an 8-lane byte-enable and 64-bit shifted data spanning two words.
module store_lane_gen
  import store_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] data_i,
  output logic [7:0]  be8_o,
  output logic [63:0] data64_o,
  output logic        legal_o
);

  logic [3:0]  base_be;
  logic [31:0] masked;

  always_comb begin
    base_be = 4'b0000;
    masked  = 32'h0;
    legal_o = 1'b1;
    case (funct3_i)
      F3_SB: begin base_be = 4'b0001; masked = {24'h0, data_i[7:0]};  end
      F3_SH: begin base_be = 4'b0011; masked = {16'h0, data_i[15:0]}; end
      F3_SW: begin base_be = 4'b1111; masked = data_i;                end
      default: legal_o = 1'b0;
    endcase
    be8_o    = {4'b0000, base_be} << off_i;
    data64_o = {32'h0, masked} << {off_i, 3'b000};
  end

endmodule

// File: rtl/store_data_aligner.sv
// Store data aligner: splits SB/SH/SW into word-aligned write beats with byte enables.
// Beat 0 is computed from the live request at acceptance; the upper half is kept for beat 1.
module store_data_aligner
  import store_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                clk,
  input  logic                reset,
  store_data_aligner_if.slave bus
);

  state_e                state_q, state_d;
  logic                  mem_valid_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [31:0]           mem_wdata_q;
  logic [3:0]            mem_be_q;
  logic [3:0]            hi_be_q;
  logic [31:0]           hi_data_q;
  logic                  illegal_q;

  logic [7:0]  be8;
  logic [63:0] data64;
  logic        f3_legal;
  logic        legal;
  logic        accept;
  logic        xfer;
  logic        unused_inst;

  store_lane_gen u_lane_gen (
    .funct3_i (bus.inst[14:12]),
    .off_i    (bus.addr[1:0]),
    .data_i   (bus.wdata_in[31:0]),
    .be8_o    (be8),
    .data64_o (data64),
    .legal_o  (f3_legal)
  );

  assign unused_inst = ^{bus.inst[WIDTH-1:15], bus.inst[11:7]};
  assign legal       = f3_legal && (bus.inst[6:0] == OPCODE_STORE);
  assign accept      = bus.req_valid && (state_q == IDLE);
  assign xfer        = mem_valid_q && bus.mem_ready;

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (accept) state_d = legal ? BEAT0 : RESP;
      BEAT0: if (xfer)   state_d = (hi_be_q != 4'b0000) ? BEAT1 : RESP;
      BEAT1: if (xfer)   state_d = RESP;
      RESP:              state_d = IDLE;
      default:           state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready = (state_q == IDLE);
    bus.done      = (state_q == RESP);
    bus.illegal   = (state_q == RESP) && illegal_q;
    bus.mem_valid = mem_valid_q;
    bus.mem_addr  = mem_addr_q;
    bus.mem_wdata = mem_wdata_q;
    bus.mem_be    = mem_be_q;
  end

  // Beat registers: loaded at accept, advanced or cleared on each transfer.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_valid_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      hi_be_q     <= '0;
      hi_data_q   <= '0;
      illegal_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          illegal_q <= ~legal;
          if (legal) begin
            mem_valid_q <= 1'b1;
            mem_addr_q  <= {bus.addr[ADDR_WIDTH-1:2], 2'b00};
            mem_be_q    <= be8[3:0];
            mem_wdata_q <= data64[31:0];
            hi_be_q     <= be8[7:4];
            hi_data_q   <= data64[63:32];
          end
        end
        BEAT0: if (xfer) begin
          if (hi_be_q != 4'b0000) begin
            mem_addr_q  <= mem_addr_q + ADDR_WIDTH'(4);
            mem_be_q    <= hi_be_q;
            mem_wdata_q <= hi_data_q;
          end else begin
            mem_valid_q <= 1'b0;
            mem_be_q    <= '0;
            mem_wdata_q <= '0;
          end
        end
        BEAT1: if (xfer) begin
          mem_valid_q <= 1'b0;
          mem_be_q    <= '0;
          mem_wdata_q <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_store_data_aligner.sv
// Directed bench for store_data_aligner with hand-computed beats and done timing.
module tb_store_data_aligner;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  store_data_aligner_if #(.WIDTH(32), .ADDR_WIDTH(32)) bus ();

  store_data_aligner #(.WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] I_SB  = 32'h0000_0023;
  localparam logic [31:0] I_SH  = 32'h0000_1023;
  localparam logic [31:0] I_SW  = 32'h0000_2023;
  localparam logic [31:0] I_F3B = 32'h0000_3023;
  localparam logic [31:0] I_LW  = 32'h0000_2003;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at posedge+1 with the DUT idle; returns at posedge+1 of the cycle after done.
  task automatic run_req(input string name, input logic [31:0] inst, input logic [31:0] a,
                         input logic [31:0] wd, input int stall, input int nbeats,
                         input logic [31:0] ea0, input logic [3:0] eb0, input logic [31:0] ed0,
                         input logic [31:0] ea1, input logic [3:0] eb1, input logic [31:0] ed1,
                         input logic exp_ill, input int exp_done);
    int   cyc, beat, waitc;
    logic seen_done;
    chk({name, " ready"}, bus.req_ready, 1);
    bus.req_valid = 1'b1;
    bus.inst      = inst;
    bus.addr      = a;
    bus.wdata_in  = wd;
    bus.mem_ready = 1'b0;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.inst      = 32'hFFFF_FFFF;
    bus.addr      = 32'h5555_5555;
    bus.wdata_in  = 32'hA5A5_A5A5;
    cyc = 1; beat = 0; waitc = 0; seen_done = 1'b0;
    while (!seen_done && cyc < 40) begin
      if (bus.mem_valid) begin
        bus.mem_ready = (waitc >= stall);
        waitc++;
      end else begin
        bus.mem_ready = 1'b0;
      end
      @(negedge clk);
      chk({name, " busy"}, bus.req_ready, 0);
      if (bus.mem_valid) begin
        if (beat >= nbeats) chk({name, " extra beat"}, bus.mem_valid, 0);
        else begin
          chk({name, " addr"}, bus.mem_addr,  (beat == 0) ? ea0 : ea1);
          chk({name, " be"},   bus.mem_be,    (beat == 0) ? eb0 : eb1);
          chk({name, " data"}, bus.mem_wdata, (beat == 0) ? ed0 : ed1);
        end
      end
      if (bus.done) begin
        seen_done = 1'b1;
        chk({name, " done cycle"}, cyc, exp_done);
        chk({name, " illegal"}, bus.illegal, exp_ill);
        chk({name, " beats"}, beat, nbeats);
      end
      if (bus.mem_valid && bus.mem_ready) begin
        beat++;
        waitc = 0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    chk({name, " timeout"}, seen_done, 1);
    chk({name, " done pulse"}, bus.done, 0);
    chk({name, " back idle"}, bus.req_ready, 1);
  endtask

  initial begin
    reset         = 1'b1;
    bus.req_valid = 1'b0;
    bus.inst      = '0;
    bus.addr      = '0;
    bus.wdata_in  = '0;
    bus.mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst mem_valid", bus.mem_valid, 0);
    chk("rst mem_addr",  bus.mem_addr,  0);
    chk("rst mem_wdata", bus.mem_wdata, 0);
    chk("rst mem_be",    bus.mem_be,    0);
    chk("rst done",      bus.done,      0);
    chk("rst illegal",   bus.illegal,   0);
    reset = 1'b0;
    chk("rst ready", bus.req_ready, 1);

    run_req("sw_aligned", I_SW, 32'h0000_0100, 32'hDEAD_BEEF, 0, 1,
            32'h0000_0100, 4'b1111, 32'hDEAD_BEEF, 32'h0, 4'b0, 32'h0, 1'b0, 2);
    run_req("sb_lane3", I_SB, 32'h0000_0203, 32'h1234_56AB, 0, 1,
            32'h0000_0200, 4'b1000, 32'hAB00_0000, 32'h0, 4'b0, 32'h0, 1'b0, 2);
    run_req("sh_lane2", I_SH, 32'h0000_0302, 32'h0000_CAFE, 0, 1,
            32'h0000_0300, 4'b1100, 32'hCAFE_0000, 32'h0, 4'b0, 32'h0, 1'b0, 2);
    run_req("sh_split", I_SH, 32'h0000_0303, 32'h0000_BEEF, 0, 2,
            32'h0000_0300, 4'b1000, 32'hEF00_0000, 32'h0000_0304, 4'b0001, 32'h0000_00BE, 1'b0, 3);
    run_req("sw_stall", I_SW, 32'h0000_0401, 32'h1122_3344, 3, 2,
            32'h0000_0400, 4'b1110, 32'h2233_4400, 32'h0000_0404, 4'b0001, 32'h0000_0011, 1'b0, 9);
    run_req("sw_wrap", I_SW, 32'hFFFF_FFFE, 32'h1122_3344, 0, 2,
            32'hFFFF_FFFC, 4'b1100, 32'h3344_0000, 32'h0000_0000, 4'b0011, 32'h0000_1122, 1'b0, 3);
    run_req("f3_bad", I_F3B, 32'h0000_0500, 32'h1234_5678, 0, 0,
            32'h0, 4'b0, 32'h0, 32'h0, 4'b0, 32'h0, 1'b1, 1);
    run_req("op_bad", I_LW, 32'h0000_0600, 32'h1234_5678, 0, 0,
            32'h0, 4'b0, 32'h0, 32'h0, 4'b0, 32'h0, 1'b1, 1);
    run_req("sb_lane0", I_SB, 32'h0000_0700, 32'hFFFF_FF5A, 0, 1,
            32'h0000_0700, 4'b0001, 32'h0000_005A, 32'h0, 4'b0, 32'h0, 1'b0, 2);

    // Reset while the second beat of a split store is stalled
    chk("mid ready", bus.req_ready, 1);
    bus.req_valid = 1'b1;
    bus.inst      = I_SW;
    bus.addr      = 32'h0000_0401;
    bus.wdata_in  = 32'h1122_3344;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.mem_ready = 1'b1;
    @(negedge clk);
    chk("mid beat0 addr", bus.mem_addr, 32'h0000_0400);
    @(posedge clk); #1;
    bus.mem_ready = 1'b0;
    @(negedge clk);
    chk("mid beat1 valid", bus.mem_valid, 1);
    chk("mid beat1 addr",  bus.mem_addr,  32'h0000_0404);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("mid rst mem_valid", bus.mem_valid, 0);
    chk("mid rst mem_be",    bus.mem_be,    0);
    chk("mid rst mem_addr",  bus.mem_addr,  0);
    chk("mid rst mem_wdata", bus.mem_wdata, 0);
    chk("mid rst done",      bus.done,      0);
    chk("mid rst ready",     bus.req_ready, 1);

    run_req("post_rst", I_SW, 32'h0000_0800, 32'hCAFE_F00D, 1, 1,
            32'h0000_0800, 4'b1111, 32'hCAFE_F00D, 32'h0, 4'b0, 32'h0, 1'b0, 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/store_data_aligner.md
Name: store_data_aligner

Overview:
Write-side counterpart of the load-data sign/zero-extension path. It accepts one store instruction (SB/SH/SW), the effective address, and the rs2 data. It produces word-aligned memory write beats with byte enables and lane-shifted data over a valid/ready handshake. Stores that cross a word boundary are split into two beats. The block sits between the execute stage and the data memory write port.

Parameters:
WIDTH, 32, data/instruction width; only 32 supported
ADDR_WIDTH, 32, byte address width

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
req_valid  input  1  store request valid
req_ready  output  1  block can accept a request (high only in IDLE)
inst  input  WIDTH  store instruction; opcode inst[6:0], funct3 inst[14:12]
addr  input  ADDR_WIDTH  effective byte address
wdata_in  input  WIDTH  rs2 store data
mem_valid  output  1  write beat valid
mem_ready  input  1  memory accepts beat
mem_addr  output  ADDR_WIDTH  word-aligned beat address, low 2 bits always 0
mem_wdata  output  WIDTH  lane-shifted write data; disabled lanes driven 0
mem_be  output  4  byte enables, bit i = byte lane i
done  output  1  one-cycle pulse when the request completes
illegal  output  1  one-cycle pulse, coincident with done, for a rejected request

Behaviour:
- Clock and reset: single clock clk. reset is synchronous and active-high.
- Reset values: state=IDLE, mem_valid=0, mem_addr=0, mem_wdata=0, mem_be=0, done=0, illegal=0. req_ready=1 on the first cycle after reset.
- States:
  - IDLE: req_ready=1.
  - BEAT0: first beat.
  - BEAT1: second beat.
  - RESP: one cycle; done=1, plus illegal if applicable; req_ready=0.
- Acceptance: a request is accepted when req_valid && req_ready. inst, addr and wdata_in are registered on acceptance.
- Legality check: opcode must be 0100011 and funct3 must be in {000 SB, 001 SH, 010 SW}. Otherwise IDLE->RESP with illegal=1 and no mem_valid.
- Lane computation (off = addr[1:0]):
  - base_be = 0001 (SB), 0011 (SH), 1111 (SW).
  - be8 = base_be << off (8 bits).
  - data64 = zero-extended masked data << (8*off). Mask keeps the low 8 bits for SB, low 16 bits for SH, all 32 for SW.
- Beat 0: mem_addr = {addr[ADDR_WIDTH-1:2],2'b00}, mem_be = be8[3:0], mem_wdata = data64[31:0].
- Beat 1: issued only if be8[7:4] != 0. mem_addr = beat0 address + 4, wrapping modulo 2^ADDR_WIDTH. mem_be = be8[7:4], mem_wdata = data64[63:32].
- Handshake: the beat transfers on mem_valid && mem_ready. mem_valid, mem_addr, mem_wdata and mem_be are registered and held stable until the transfer. mem_valid never drops without a transfer, except on reset.
- Transitions:
  - IDLE->BEAT0 on a legal accept.
  - BEAT0->BEAT1 on transfer when a second beat is needed, else BEAT0->RESP.
  - BEAT1->RESP on transfer.
  - RESP->IDLE unconditionally.
- Latency: accept at cycle 0, mem_valid at cycle 1.
  - Aligned request with mem_ready=1: done at cycle 2, next accept at cycle 3.
  - Split request: done at cycle 3 minimum.
- Reset mid-operation: the transaction is abandoned and the outputs return to their reset values on the next edge. A partially written first beat is not rolled back.
- Simultaneous events: a new req_valid during BEAT0, BEAT1 or RESP is ignored (req_ready=0). Upstream must hold the request.

Decomposition:
- Package store_pkg:
  - OPCODE_STORE = 7'b0100011.
  - F3_SB/F3_SH/F3_SW constants.
  - state enum {IDLE, BEAT0, BEAT1, RESP}.
- Sub-module store_lane_gen, purely combinational: (funct3, off, data) -> (be8, data64, legal).
- The top level holds the FSM and the output registers.

Test Plan:
1. SW addr 0x100, wdata 0xDEADBEEF, mem_ready=1 -> single beat addr 0x100, be 1111, wdata 0xDEADBEEF; done at cycle 2; illegal=0.
2. SB addr 0x203, wdata 0x123456AB -> single beat addr 0x200, be 1000, wdata 0xAB000000.
3. SH addr 0x302, wdata 0x0000CAFE -> single beat addr 0x300, be 1100, wdata 0xCAFE0000.
   SH addr 0x303, wdata 0xBEEF -> beat0 0x300/1000/0xEF000000, then beat1 0x304/0001/0x000000BE.
4. SW addr 0x401, wdata 0x11223344, mem_ready low 3 cycles per beat -> beat0 0x400/1110/0x22334400 and beat1 0x404/0001/0x00000011, each held stable while stalled; done after the beat1 transfer.
5. SW addr 0xFFFFFFFE, wdata 0x11223344 -> beat0 0xFFFFFFFC/1100/0x33440000, then beat1 0x00000000/0011/0x00001122 (address wrap).
6. Two error cases:
   - funct3 011 with the store opcode -> no mem_valid; done=illegal=1 at cycle 1.
   - reset asserted while BEAT1 is stalled -> mem_valid=0, be=0, req_ready=1 after the reset edge.
